// File: rtl/exec_commit_pkg.sv
// exec_commit_pkg: shared CPU constants for the execute/commit stage.
//   - DATAOP opcode and ARM condition-code encodings
//   - commit FSM state typedef
//   - helpers classifying opcodes as test ops or logical ops
package exec_commit_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_EOR = 4'h1,
    OP_SUB = 4'h2,
    OP_RSB = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SBC = 4'h6,
    OP_RSC = 4'h7,
    OP_TST = 4'h8,
    OP_TEQ = 4'h9,
    OP_CMP = 4'hA,
    OP_CMN = 4'hB,
    OP_ORR = 4'hC,
    OP_MOV = 4'hD,
    OP_BIC = 4'hE,
    OP_MVN = 4'hF
  } dataop_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } commit_state_e;

  localparam int FLUSH_CNT_W = 3;

  // Test ops update flags but never write a destination register.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  // Logical ops take C from the shifter and leave V untouched.
  function automatic logic is_logical_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_EOR) || (op == OP_TST) || (op == OP_TEQ) ||
           (op == OP_ORR) || (op == OP_MOV) || (op == OP_BIC) || (op == OP_MVN);
  endfunction

endpackage

// File: rtl/exec_commit_cond_check.sv
// cond_check: combinational ARM condition evaluation, shared with decode.
// Ports:
//   cond [3:0]  condition field of the instruction
//   nzcv [3:0]  current flags, N in bit 3
//   pass        1 when the instruction should execute
module cond_check
  import exec_commit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[3];
  assign z = nzcv[2];
  assign c = nzcv[1];
  assign v = nzcv[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;  // reserved NV encoding never executes
    endcase
  end

endmodule

// File: rtl/exec_commit.sv
// exec_commit: execute/commit stage. Applies condition codes, commits flags,
// registers writebacks and issues branch redirects followed by a squash window.
// Ports:
//   clk, nreset                   clock, async active-low reset
//   in_valid/in_ready             issue handshake from decode
//   in_cond, in_opcode            condition field, DATAOP opcode
//   in_set_flags, in_writes_rd, in_is_branch, in_shifter_carry
//   in_rd, in_branch_target       destination register, branch target
//   alu_result, alu_n/z/c/v       ALU outputs for the presented instruction
//   out_valid/out_ready           writeback handshake
//   out_rd, out_data              writeback payload
//   branch_taken, branch_target, flush   redirect to fetch/decode
//   cpsr_nzcv                     architectural flags, N in bit 3
// Optional (macro EXEC_COMMIT_STATS_EN):
//   stat_executed, stat_annulled  saturating counts of passed/failed accepts
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal issue; accepts when the writeback slot is free
// ST_FLUSH | squash window after a taken branch; every beat is discarded
module exec_commit
  import exec_commit_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2  // legal 1..7
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_opcode,
  input  logic        in_set_flags,
  input  logic        in_writes_rd,
  input  logic        in_is_branch,
  input  logic        in_shifter_carry,
  input  logic [3:0]  in_rd,
  input  logic [31:0] in_branch_target,
  input  logic [31:0] alu_result,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_rd,
  output logic [31:0] out_data,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        flush,
  output logic [3:0]  cpsr_nzcv
`ifdef EXEC_COMMIT_STATS_EN
  ,
  output logic [15:0] stat_executed,
  output logic [15:0] stat_annulled
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_DEPTH);

  commit_state_e          state;
  logic [FLUSH_CNT_W-1:0] cnt;
  logic                   cond_pass;
  logic                   accept_run;
  logic                   test_op;
  logic                   flag_update;
  logic [3:0]             nzcv_next;

  cond_check u_cond_check (
    .cond (in_cond),
    .nzcv (cpsr_nzcv),
    .pass (cond_pass)
  );

  // In FLUSH the stage swallows everything, so it never back-pressures.
  assign in_ready   = (state == ST_FLUSH) ? 1'b1 : (~out_valid | out_ready);
  assign accept_run = (state == ST_RUN) & in_valid & in_ready;
  assign test_op    = is_test_op(in_opcode);
  assign flag_update = in_set_flags | test_op;

  always_comb begin
    nzcv_next = {alu_n, alu_z, alu_c, alu_v};
    if (is_logical_op(in_opcode)) begin
      nzcv_next = {alu_n, alu_z, in_shifter_carry, cpsr_nzcv[0]};
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= ST_RUN;
      cnt           <= '0;
      cpsr_nzcv     <= 4'b0000;
      out_valid     <= 1'b0;
      out_rd        <= 4'd0;
      out_data      <= 32'd0;
      branch_taken  <= 1'b0;
      flush         <= 1'b0;
      branch_target <= 32'd0;
    end else begin
      branch_taken <= 1'b0;
      flush        <= 1'b0;

      // A new writeback loaded below overrides this clear on the same edge.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_RUN: begin
          if (accept_run && cond_pass) begin
            if (flag_update) begin
              cpsr_nzcv <= nzcv_next;
            end
            if (in_writes_rd && !test_op) begin
              out_valid <= 1'b1;
              out_rd    <= in_rd;
              out_data  <= alu_result;
            end
            if (in_is_branch) begin
              branch_taken  <= 1'b1;
              flush         <= 1'b1;
              branch_target <= in_branch_target;
              state         <= ST_FLUSH;
              cnt           <= FLUSH_LOAD;
            end
          end
        end
        ST_FLUSH: begin
          // <= 1 also recovers from a zero count rather than wrapping.
          if (cnt <= FLUSH_CNT_W'(1)) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - FLUSH_CNT_W'(1);
          end
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef EXEC_COMMIT_STATS_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stat_executed <= 16'd0;
      stat_annulled <= 16'd0;
    end else if (accept_run) begin
      if (cond_pass) begin
        if (stat_executed != 16'hFFFF) stat_executed <= stat_executed + 16'd1;
      end else begin
        if (stat_annulled != 16'hFFFF) stat_annulled <= stat_annulled + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exec_commit.sv
module tb_exec_commit;
  import exec_commit_pkg::*;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cond = 4'd0;
  logic [3:0]  in_opcode = 4'd0;
  logic        in_set_flags = 1'b0;
  logic        in_writes_rd = 1'b0;
  logic        in_is_branch = 1'b0;
  logic        in_shifter_carry = 1'b0;
  logic [3:0]  in_rd = 4'd0;
  logic [31:0] in_branch_target = 32'd0;
  logic [31:0] alu_result = 32'd0;
  logic        alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_rd;
  logic [31:0] out_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        flush;
  logic [3:0]  cpsr_nzcv;
`ifdef EXEC_COMMIT_STATS_EN
  logic [15:0] stat_executed;
  logic [15:0] stat_annulled;
  logic [15:0] ann_before;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         wb_q[$];
  logic [31:0] br_q[$];

  exec_commit #(.FLUSH_DEPTH(2)) dut (
    .clk              (clk),
    .nreset           (nreset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_cond          (in_cond),
    .in_opcode        (in_opcode),
    .in_set_flags     (in_set_flags),
    .in_writes_rd     (in_writes_rd),
    .in_is_branch     (in_is_branch),
    .in_shifter_carry (in_shifter_carry),
    .in_rd            (in_rd),
    .in_branch_target (in_branch_target),
    .alu_result       (alu_result),
    .alu_n            (alu_n),
    .alu_z            (alu_z),
    .alu_c            (alu_c),
    .alu_v            (alu_v),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_rd           (out_rd),
    .out_data         (out_data),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .flush            (flush),
    .cpsr_nzcv        (cpsr_nzcv)
`ifdef EXEC_COMMIT_STATS_EN
    ,
    .stat_executed    (stat_executed),
    .stat_annulled    (stat_annulled)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one instruction and returns #1 after the edge that accepts it.
  task automatic issue(input logic [3:0] cond, input logic [3:0] op, input logic s,
                       input logic wr, input logic br, input logic sc,
                       input logic [3:0] rd, input logic [31:0] tgt,
                       input logic [31:0] res, input logic [3:0] f);
    logic acc;
    in_cond = cond; in_opcode = op; in_set_flags = s; in_writes_rd = wr;
    in_is_branch = br; in_shifter_carry = sc; in_rd = rd; in_branch_target = tgt;
    alu_result = res; {alu_n, alu_z, alu_c, alu_v} = f;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    checks++;
    errors++;
    $display("FAIL issue_timeout: in_ready never rose, got 0 expected 1");
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops expected writebacks/redirects when the DUT presents them.
  initial forever begin
    @(negedge clk);
    if (nreset && out_valid && out_ready) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", {28'd0, out_rd}, 32'hFFFF_FFFF);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        chk("wb_rd", {28'd0, out_rd}, {28'd0, e.rd});
        chk("wb_data", out_data, e.data);
      end
    end
    if (nreset && branch_taken) begin
      if (br_q.size() == 0) begin
        chk("br_unexpected", branch_target, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] t;
        t = br_q.pop_front();
        chk("br_target", branch_target, t);
        chk("br_flush", {31'd0, flush}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cpsr", {28'd0, cpsr_nzcv}, 32'd0);
    chk("rst_branch_taken", {31'd0, branch_taken}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_branch_target", branch_target, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #20 nreset = 1'b1;
    @(posedge clk); #1;

    // SUBS r3 with Z result, then MOVEQ r1, #5
    wb_q.push_back('{rd: 4'd3, data: 32'd0});
    issue(COND_AL, OP_SUB, 1, 1, 0, 0, 4'd3, 32'd0, 32'd0, 4'b0100);
    chk("subs_flags", {28'd0, cpsr_nzcv}, 32'b0100);
    wb_q.push_back('{rd: 4'd1, data: 32'd5});
    issue(COND_EQ, OP_MOV, 0, 1, 0, 0, 4'd1, 32'd0, 32'd5, 4'b0000);
    chk("moveq_flags_kept", {28'd0, cpsr_nzcv}, 32'b0100);

    // CMP clears flags, ADDNES loads 1001, EORS keeps V -> 0101
    issue(COND_AL, OP_CMP, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 4'b0000);
    chk("cmp_clear", {28'd0, cpsr_nzcv}, 32'b0000);
    wb_q.push_back('{rd: 4'd2, data: 32'h8000_0001});
    issue(COND_NE, OP_ADD, 1, 1, 0, 0, 4'd2, 32'd0, 32'h8000_0001, 4'b1001);
    chk("addnes_flags", {28'd0, cpsr_nzcv}, 32'b1001);
    wb_q.push_back('{rd: 4'd4, data: 32'd0});
    issue(COND_AL, OP_EOR, 1, 1, 0, 0, 4'd4, 32'd0, 32'd0, 4'b0110);
    chk("eors_flags", {28'd0, cpsr_nzcv}, 32'b0101);

    // CMP with Z=0, then BEQ is annulled
    issue(COND_AL, OP_CMP, 0, 0, 0, 0, 4'd0, 32'd0, 32'd1, 4'b0010);
    chk("cmp_nz", {28'd0, cpsr_nzcv}, 32'b0010);
`ifdef EXEC_COMMIT_STATS_EN
    ann_before = stat_annulled;
`endif
    issue(COND_EQ, OP_ADD, 0, 0, 1, 0, 4'd0, 32'h200, 32'h200, 4'b1111);
    chk("beq_no_branch", {31'd0, branch_taken}, 32'd0);
    chk("beq_flags_kept", {28'd0, cpsr_nzcv}, 32'b0010);
`ifdef EXEC_COMMIT_STATS_EN
    chk("stat_annulled_inc", {16'd0, stat_annulled}, {16'd0, ann_before + 16'd1});
`endif

    // B 0x100: two beats dropped, third executes
    br_q.push_back(32'h100);
    issue(COND_AL, OP_ADD, 0, 0, 1, 0, 4'd0, 32'h100, 32'h100, 4'b0000);
    chk("b_taken", {31'd0, branch_taken}, 32'd1);
    chk("b_target", branch_target, 32'h100);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    issue(COND_AL, OP_MOV, 0, 1, 0, 0, 4'd5, 32'd0, 32'h55, 4'b0000);
    issue(COND_AL, OP_MOV, 0, 1, 0, 0, 4'd6, 32'd0, 32'h66, 4'b0000);
    wb_q.push_back('{rd: 4'd7, data: 32'h77});
    issue(COND_AL, OP_MOV, 0, 1, 0, 0, 4'd7, 32'd0, 32'h77, 4'b0000);
    // BL: writeback and redirect together
    wb_q.push_back('{rd: 4'd14, data: 32'h1234});
    br_q.push_back(32'h400);
    issue(COND_AL, OP_ADD, 0, 1, 1, 0, 4'd14, 32'h400, 32'h1234, 4'b0000);
    idle(4);

    // Writeback stall with out_ready low
    out_ready = 1'b0;
    wb_q.push_back('{rd: 4'd8, data: 32'hDEAD});
    issue(COND_AL, OP_MOV, 0, 1, 0, 0, 4'd8, 32'd0, 32'hDEAD, 4'b0000);
    wb_q.push_back('{rd: 4'd9, data: 32'hBEEF});
    in_rd = 4'd9; alu_result = 32'hBEEF; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_data", out_data, 32'hDEAD);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd1);
    chk("release_data", out_data, 32'hBEEF);
    idle(3);

    // Reset during FLUSH
    br_q.push_back(32'h300);
    issue(COND_AL, OP_ADD, 0, 0, 1, 0, 4'd0, 32'h300, 32'h300, 4'b0000);
    in_valid = 1'b0;
    @(negedge clk); #1;
    nreset = 1'b0;
    #1;
    chk("mid_rst_branch", {31'd0, branch_taken}, 32'd0);
    chk("mid_rst_flush", {31'd0, flush}, 32'd0);
    chk("mid_rst_target", branch_target, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    #1 nreset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_cpsr", {28'd0, cpsr_nzcv}, 32'd0);
    wb_q.push_back('{rd: 4'd10, data: 32'h77});
    issue(COND_AL, OP_MOV, 0, 1, 0, 0, 4'd10, 32'd0, 32'h77, 4'b0000);
    idle(5);

    chk("wb_queue_drained", wb_q.size(), 32'd0);
    chk("br_queue_drained", br_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
